weight_tap_streamer: RTL

WEIGHT_TAP_STREAMER -- requirements
Module: weight_tap_streamer

---
 rtl/weight_tap_streamer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/weight_tap_streamer.sv
// ---------------------------------------------------------------------------
// weight_tap_streamer
//
// Purpose:
//   Banked weight buffer that DDR fills one bank at a time. On request it
//   streams a run of consecutive rows (one row per kernel tap) into a wide
//   kernel register, then holds the kernel under a valid/ready handshake.
//
// Optional build macro:
//   WBUF_RD_PIPE_EN - adds an output register after each bank. Bank read
//                     latency becomes 2 cycles and ker_valid_o arrives at
//                     taps+3 cycles instead of taps+2.
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset (RAM contents are kept)
//   wr_en_i      - per-bank write enable [BANKS]
//   wr_addr_i    - write row address, shared by all banks
//   wr_data_i    - write word, broadcast to every enabled bank
//   rd_start_i   - kernel fetch request
//   rd_addr_i    - first row of the kernel
//   rd_taps_i    - number of taps (rows) to fetch, 1..KMAX
//   busy_o       - FSM is not idle
//   err_cfg_o    - one-cycle pulse for a request with an illegal tap count
//   ker_valid_o  - kernel output is valid
//   ker_ready_i  - consumer accepts the kernel
//   ker_data_o   - kernel, slot t at [t*ROW_W +: ROW_W]
// ---------------------------------------------------------------------------
module weight_tap_streamer #(
  parameter int BANKS        = 4,
  parameter int DDR_DATA_LEN = 256,
  parameter int ADDR_LEN     = 10,
  parameter int KMAX         = 9,
  localparam int ROW_W       = BANKS * DDR_DATA_LEN,
  localparam int TAPW        = $clog2(KMAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BANKS-1:0]        wr_en_i,
  input  logic [ADDR_LEN-1:0]     wr_addr_i,
  input  logic [DDR_DATA_LEN-1:0] wr_data_i,
  input  logic                    rd_start_i,
  input  logic [ADDR_LEN-1:0]     rd_addr_i,
  input  logic [TAPW-1:0]         rd_taps_i,
  output logic                    busy_o,
  output logic                    err_cfg_o,
  output logic                    ker_valid_o,
  input  logic                    ker_ready_i,
  output logic [KMAX*ROW_W-1:0]   ker_data_o
);

  localparam logic [TAPW-1:0] KMAX_T = TAPW'(KMAX);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_e;

  state_e              state_q;
  logic                busy_q;
  logic                err_q;
  logic                valid_q;
  logic                done_q;
  logic [ADDR_LEN-1:0] base_q;
  logic [TAPW-1:0]     taps_q;
  logic [TAPW-1:0]     cnt_q;

  // Tag travelling alongside the bank read data (one cycle behind the issue).
  logic                s1_vld_q;
  logic                s1_last_q;
  logic [TAPW-1:0]     s1_idx_q;

  // Tag aligned with the row that is being captured this cycle.
  logic                cap_vld;
  logic                cap_last;
  logic [TAPW-1:0]     cap_idx;

  logic [ADDR_LEN-1:0] rd_ptr;
  logic [ROW_W-1:0]    row_rd;
  logic                taps_ok;
  logic                start_ok;
  logic                issue;

  logic [ROW_W-1:0]    slot_q [KMAX];

  assign taps_ok  = (rd_taps_i != '0) && (rd_taps_i <= KMAX_T);
  assign start_ok = rd_start_i && taps_ok;

  // One row is issued per FETCH cycle until all taps have been requested;
  // the FSM stays in FETCH while the tail of the read pipeline drains.
  assign issue    = (state_q == FETCH) && (cnt_q != taps_q);

  // Natural ADDR_LEN-bit overflow gives the modulo-depth wrap.
  assign rd_ptr   = base_q + ADDR_LEN'(cnt_q);

  // -------------------------------------------------------------------------
  // RAM banks: simple dual-port, read-first (the nonblocking write means a
  // same-cycle read of the written row returns the old word).
  // -------------------------------------------------------------------------
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DDR_DATA_LEN-1:0] mem [2**ADDR_LEN];
    logic [DDR_DATA_LEN-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (wr_en_i[b]) begin
        mem[wr_addr_i] <= wr_data_i;
      end
      dout_q <= mem[rd_ptr];
    end

`ifdef WBUF_RD_PIPE_EN
    logic [DDR_DATA_LEN-1:0] dout2_q;

    always_ff @(posedge clk) begin
      dout2_q <= dout_q;
    end

    assign row_rd[b*DDR_DATA_LEN +: DDR_DATA_LEN] = dout2_q;
`else
    assign row_rd[b*DDR_DATA_LEN +: DDR_DATA_LEN] = dout_q;
`endif
  end

`ifdef WBUF_RD_PIPE_EN
  // Extra tag stage matching the bank output register.
  logic            s2_vld_q;
  logic            s2_last_q;
  logic [TAPW-1:0] s2_idx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_idx_q  <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      s2_idx_q  <= s1_idx_q;
    end
  end

  assign cap_vld  = s2_vld_q;
  assign cap_last = s2_last_q;
  assign cap_idx  = s2_idx_q;
`else
  assign cap_vld  = s1_vld_q;
  assign cap_last = s1_last_q;
  assign cap_idx  = s1_idx_q;
`endif

  // -------------------------------------------------------------------------
  // Control FSM, read tagging and kernel capture. All outputs are registered.
  // The last row lands in its slot one cycle before ker_valid rises (done_q),
  // so the kernel is complete and stable for the whole valid window.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      base_q    <= '0;
      taps_q    <= '0;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_idx_q  <= '0;
      for (int t = 0; t < KMAX; t++) begin
        slot_q[t] <= '0;
      end
    end else begin
      err_q     <= rd_start_i && !taps_ok;

      s1_vld_q  <= issue;
      s1_idx_q  <= cnt_q;
      s1_last_q <= issue && (cnt_q == taps_q - 1'b1);

      done_q    <= cap_vld && cap_last;

      // Unused slots are cleared together with the first captured row.
      for (int t = 0; t < KMAX; t++) begin
        if (cap_vld && (cap_idx == '0) && (TAPW'(t) >= taps_q)) begin
          slot_q[t] <= '0;
        end
        if (cap_vld && (cap_idx == TAPW'(t))) begin
          slot_q[t] <= row_rd;
        end
      end

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= FETCH;
            busy_q  <= 1'b1;
            base_q  <= rd_addr_i;
            taps_q  <= rd_taps_i;
            cnt_q   <= '0;
          end
        end
        FETCH: begin
          if (issue) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (done_q) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (ker_ready_i) begin
            valid_q <= 1'b0;
            if (start_ok) begin
              state_q <= FETCH;
              base_q  <= rd_addr_i;
              taps_q  <= rd_taps_i;
              cnt_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar t = 0; t < KMAX; t++) begin : g_slot
    assign ker_data_o[t*ROW_W +: ROW_W] = slot_q[t];
  end

  assign busy_o      = busy_q;
  assign err_cfg_o   = err_q;
  assign ker_valid_o = valid_q;

endmodule
